// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-first bypass, three forwarded read ports,
// branch-and-link write-back, and an ID/EX register with stall, flush and a stall counter.
module decode_stage_pipe #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned PC_W     = 9,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned CTRL_W   = 16,
    parameter int unsigned LINK_REG = 29,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall_d,
    input  logic              i_flush_d,
    input  logic              i_valid_d,
    input  logic [CTRL_W-1:0] i_ctrl_d,
    input  logic [DATA_W-1:0] i_imm_d,
    input  logic [ADDR_W-1:0] i_ra1_d,
    input  logic [ADDR_W-1:0] i_ra2_d,
    input  logic [ADDR_W-1:0] i_ra3_d,
    input  logic [ADDR_W-1:0] i_rd_d,
    input  logic [PC_W-1:0]   i_pc_d,
    input  logic [PC_W-1:0]   i_pcplus_d,
    input  logic              i_fwd_a,
    input  logic              i_fwd_b,
    input  logic              i_fwd_c,
    input  logic              i_we_w,
    input  logic              i_link_w,
    input  logic [ADDR_W-1:0] i_wa_w,
    input  logic [DATA_W-1:0] i_result_w,
    input  logic [PC_W-1:0]   i_pc_w,
    output logic              o_valid_e,
    output logic [CTRL_W-1:0] o_ctrl_e,
    output logic [DATA_W-1:0] o_rd1_e,
    output logic [DATA_W-1:0] o_rd2_e,
    output logic [DATA_W-1:0] o_rd3_e,
    output logic [DATA_W-1:0] o_imm_e,
    output logic [ADDR_W-1:0] o_rs1_e,
    output logic [ADDR_W-1:0] o_rs2_e,
    output logic [ADDR_W-1:0] o_rs3_e,
    output logic [ADDR_W-1:0] o_rd_e,
    output logic [PC_W-1:0]   o_pc_e,
    output logic [PC_W-1:0]   o_pcplus_e,
    output logic [PC_W-1:0]   o_link_e,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W + 1)'(NREGS);
    localparam logic [ADDR_W-1:0] LINK_A  = ADDR_W'(LINK_REG);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_wd;
    logic              w_wa_ok;
    logic              w_we_ok;

    assign w_wd    = i_link_w ? DATA_W'(i_pc_w) : i_result_w;
    assign w_wa_ok = (i_wa_w != '0) && ({1'b0, i_wa_w} < NREGS_A);
    assign w_we_ok = i_we_w && w_wa_ok;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_ok) begin
            r_regs[i_wa_w] <= w_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: external forward, then same-cycle write bypass, then array
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_ra  [3];
    logic [2:0]        w_fwd;
    logic [DATA_W-1:0] w_rd  [3];
    logic [PC_W-1:0]   w_link_d;

    assign w_ra[0] = i_ra1_d;
    assign w_ra[1] = i_ra2_d;
    assign w_ra[2] = i_ra3_d;
    assign w_fwd   = {i_fwd_c, i_fwd_b, i_fwd_a};

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            w_rd[n] = '0;
            if (w_fwd[n]) begin
                w_rd[n] = i_result_w;
            end else if ((w_ra[n] != '0) && ({1'b0, w_ra[n]} < NREGS_A)) begin
                if (i_we_w && (i_wa_w == w_ra[n])) begin
                    w_rd[n] = w_wd;
                end else begin
                    w_rd[n] = r_regs[w_ra[n]];
                end
            end
        end
    end

    always_comb begin
        w_link_d = r_regs[LINK_REG][PC_W-1:0];
        if (i_we_w && (i_wa_w == LINK_A) && (LINK_A != '0)) begin
            w_link_d = w_wd[PC_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register: flush beats stall, stall beats load
    // ------------------------------------------------------------------
    logic              r_valid_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [DATA_W-1:0] r_rd1_e;
    logic [DATA_W-1:0] r_rd2_e;
    logic [DATA_W-1:0] r_rd3_e;
    logic [DATA_W-1:0] r_imm_e;
    logic [ADDR_W-1:0] r_rs1_e;
    logic [ADDR_W-1:0] r_rs2_e;
    logic [ADDR_W-1:0] r_rs3_e;
    logic [ADDR_W-1:0] r_rd_e;
    logic [PC_W-1:0]   r_pc_e;
    logic [PC_W-1:0]   r_pcplus_e;
    logic [PC_W-1:0]   r_link_e;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid_e  <= 1'b0;
            r_ctrl_e   <= '0;
            r_rd1_e    <= '0;
            r_rd2_e    <= '0;
            r_rd3_e    <= '0;
            r_imm_e    <= '0;
            r_rs1_e    <= '0;
            r_rs2_e    <= '0;
            r_rs3_e    <= '0;
            r_rd_e     <= '0;
            r_pc_e     <= '0;
            r_pcplus_e <= '0;
            r_link_e   <= '0;
        end else if (i_flush_d) begin
            r_valid_e  <= 1'b0;
            r_ctrl_e   <= '0;
            r_rd1_e    <= '0;
            r_rd2_e    <= '0;
            r_rd3_e    <= '0;
            r_imm_e    <= '0;
            r_rs1_e    <= '0;
            r_rs2_e    <= '0;
            r_rs3_e    <= '0;
            r_rd_e     <= '0;
            r_pc_e     <= '0;
            r_pcplus_e <= '0;
            r_link_e   <= '0;
        end else if (!i_stall_d) begin
            r_valid_e  <= i_valid_d;
            r_ctrl_e   <= i_valid_d ? i_ctrl_d : '0;
            r_rd1_e    <= w_rd[0];
            r_rd2_e    <= w_rd[1];
            r_rd3_e    <= w_rd[2];
            r_imm_e    <= i_imm_d;
            r_rs1_e    <= i_ra1_d;
            r_rs2_e    <= i_ra2_d;
            r_rs3_e    <= i_ra3_d;
            r_rd_e     <= i_rd_d;
            r_pc_e     <= i_pc_d;
            r_pcplus_e <= i_pcplus_d;
            r_link_e   <= w_link_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter; a flushed stall cycle is not counted
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
        end else if (i_stall_d && !i_flush_d && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_valid_e   = r_valid_e;
    assign o_ctrl_e    = r_ctrl_e;
    assign o_rd1_e     = r_rd1_e;
    assign o_rd2_e     = r_rd2_e;
    assign o_rd3_e     = r_rd3_e;
    assign o_imm_e     = r_imm_e;
    assign o_rs1_e     = r_rs1_e;
    assign o_rs2_e     = r_rs2_e;
    assign o_rs3_e     = r_rs3_e;
    assign o_rd_e      = r_rd_e;
    assign o_pc_e      = r_pc_e;
    assign o_pcplus_e  = r_pcplus_e;
    assign o_link_e    = r_link_e;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed steps plus random cycles against a register-array
// model; every output is compared after each clock edge.
module tb_decode_stage_pipe;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_d, flush_d, valid_d;
    logic [15:0] ctrl_d;
    logic [17:0] imm_d;
    logic [4:0]  ra1_d, ra2_d, ra3_d, rd_d;
    logic [8:0]  pc_d, pcplus_d;
    logic        fwd_a, fwd_b, fwd_c;
    logic        we_w, link_w;
    logic [4:0]  wa_w;
    logic [17:0] result_w;
    logic [8:0]  pc_w;

    logic        valid_e;
    logic [15:0] ctrl_e;
    logic [17:0] rd1_e, rd2_e, rd3_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rs3_e, rd_e;
    logic [8:0]  pc_e, pcplus_e, link_e;
    logic [3:0]  stall_cnt;

    decode_stage_pipe #(.CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall_d(stall_d), .i_flush_d(flush_d),
        .i_valid_d(valid_d), .i_ctrl_d(ctrl_d), .i_imm_d(imm_d),
        .i_ra1_d(ra1_d), .i_ra2_d(ra2_d), .i_ra3_d(ra3_d), .i_rd_d(rd_d),
        .i_pc_d(pc_d), .i_pcplus_d(pcplus_d),
        .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_fwd_c(fwd_c),
        .i_we_w(we_w), .i_link_w(link_w), .i_wa_w(wa_w), .i_result_w(result_w),
        .i_pc_w(pc_w),
        .o_valid_e(valid_e), .o_ctrl_e(ctrl_e),
        .o_rd1_e(rd1_e), .o_rd2_e(rd2_e), .o_rd3_e(rd3_e), .o_imm_e(imm_e),
        .o_rs1_e(rs1_e), .o_rs2_e(rs2_e), .o_rs3_e(rs3_e), .o_rd_e(rd_e),
        .o_pc_e(pc_e), .o_pcplus_e(pcplus_e), .o_link_e(link_e),
        .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [17:0] m_regs [32];
    logic        e_valid;
    logic [15:0] e_ctrl;
    logic [17:0] e_rd [3];
    logic [17:0] e_imm;
    logic [4:0]  e_rs [3];
    logic [4:0]  e_rdaddr;
    logic [8:0]  e_pc, e_pcplus, e_link;
    int          e_cnt;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] wdata();
        return link_w ? {9'b0, pc_w} : result_w;
    endfunction

    function automatic logic [17:0] mread(input logic fwd, input logic [4:0] ra);
        if (fwd) return result_w;
        if (ra == 5'd0) return 18'd0;
        if (we_w && wa_w == ra) return wdata();
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        e_valid = 0; e_ctrl = 0; e_imm = 0; e_rdaddr = 0;
        e_pc = 0; e_pcplus = 0; e_link = 0; e_cnt = 0;
        for (int i = 0; i < 3; i++) begin e_rd[i] = 0; e_rs[i] = 0; end
    endtask

    task automatic check_all();
        chk("valid_e", 32'(valid_e), 32'(e_valid));
        chk("ctrl_e", 32'(ctrl_e), 32'(e_ctrl));
        chk("rd1_e", 32'(rd1_e), 32'(e_rd[0]));
        chk("rd2_e", 32'(rd2_e), 32'(e_rd[1]));
        chk("rd3_e", 32'(rd3_e), 32'(e_rd[2]));
        chk("imm_e", 32'(imm_e), 32'(e_imm));
        chk("rs1_e", 32'(rs1_e), 32'(e_rs[0]));
        chk("rs2_e", 32'(rs2_e), 32'(e_rs[1]));
        chk("rs3_e", 32'(rs3_e), 32'(e_rs[2]));
        chk("rd_e", 32'(rd_e), 32'(e_rdaddr));
        chk("pc_e", 32'(pc_e), 32'(e_pc));
        chk("pcplus_e", 32'(pcplus_e), 32'(e_pcplus));
        chk("link_e", 32'(link_e), 32'(e_link));
        chk("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
    endtask

    // Advance one clock: predict, clock, then compare everything
    task automatic tick();
        logic [17:0] nrd [3];
        logic [8:0]  nlink;
        if (rst) begin
            nrd[0] = mread(fwd_a, ra1_d);
            nrd[1] = mread(fwd_b, ra2_d);
            nrd[2] = mread(fwd_c, ra3_d);
            nlink  = (we_w && wa_w == 5'd29) ? wdata() : m_regs[29][8:0];
            if (flush_d) begin
                e_valid = 0; e_ctrl = 0; e_imm = 0; e_rdaddr = 0;
                e_pc = 0; e_pcplus = 0; e_link = 0;
                for (int i = 0; i < 3; i++) begin e_rd[i] = 0; e_rs[i] = 0; end
            end else if (!stall_d) begin
                e_valid = valid_d;
                e_ctrl  = valid_d ? ctrl_d : 16'd0;
                for (int i = 0; i < 3; i++) e_rd[i] = nrd[i];
                e_rs[0] = ra1_d; e_rs[1] = ra2_d; e_rs[2] = ra3_d;
                e_imm = imm_d; e_rdaddr = rd_d; e_pc = pc_d; e_pcplus = pcplus_d;
                e_link = nlink;
            end
            if (stall_d && !flush_d && e_cnt < CNT_MAX) e_cnt++;
            if (we_w && wa_w != 5'd0) m_regs[wa_w] = wdata();
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        stall_d = 0; flush_d = 0; valid_d = 0; ctrl_d = 0; imm_d = 0;
        ra1_d = 0; ra2_d = 0; ra3_d = 0; rd_d = 0; pc_d = 0; pcplus_d = 0;
        fwd_a = 0; fwd_b = 0; fwd_c = 0; we_w = 0; link_w = 0; wa_w = 0;
        result_w = 0; pc_w = 0;
    endtask

    task automatic rand_inputs();
        stall_d  = ($urandom_range(0, 3) == 0);
        flush_d  = ($urandom_range(0, 7) == 0);
        valid_d  = ($urandom_range(0, 3) != 0);
        ctrl_d   = 16'($urandom);
        imm_d    = 18'($urandom);
        ra1_d    = 5'($urandom); ra2_d = 5'($urandom); ra3_d = 5'($urandom);
        rd_d     = 5'($urandom);
        pc_d     = 9'($urandom); pcplus_d = 9'($urandom);
        fwd_a    = ($urandom_range(0, 7) == 0);
        fwd_b    = ($urandom_range(0, 7) == 0);
        fwd_c    = ($urandom_range(0, 7) == 0);
        we_w     = ($urandom_range(0, 2) != 0);
        link_w   = ($urandom_range(0, 5) == 0);
        wa_w     = ($urandom_range(0, 3) == 0) ? 5'd29 : 5'($urandom);
        result_w = 18'($urandom);
        pc_w     = 9'($urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        check_all();

        // Write attempted under reset is ignored
        we_w = 1; wa_w = 5'd5; result_w = 18'h2A5A5;
        tick();
        rst = 1;
        tick();
        we_w = 0; ra1_d = 5'd5;
        tick();
        chk("tp_reset_write_rd1", 32'(rd1_e), 32'h2A5A5);

        // Bypass on same cycle, then R0 stays zero
        we_w = 1; wa_w = 5'd7; result_w = 18'h00123; ra2_d = 5'd7;
        tick();
        chk("tp_bypass_rd2", 32'(rd2_e), 32'h00123);
        wa_w = 5'd0; result_w = 18'h3FFFF; ra1_d = 5'd0; ra2_d = 5'd0;
        tick();
        we_w = 0;
        tick();
        chk("tp_r0_rd1", 32'(rd1_e), 32'h0);

        // Branch-and-link
        we_w = 1; link_w = 1; wa_w = 5'd29; pc_w = 9'h1A4; result_w = 18'h15555;
        tick();
        we_w = 0; link_w = 0; ra1_d = 5'd29;
        tick();
        chk("tp_link_rd1", 32'(rd1_e), 32'h001A4);
        chk("tp_link_e", 32'(link_e), 32'h1A4);

        // Forward priority
        we_w = 1; wa_w = 5'd3; result_w = 18'd10;
        tick();
        we_w = 0; fwd_a = 1; result_w = 18'd99; ra1_d = 5'd3;
        tick();
        chk("tp_fwd_on", 32'(rd1_e), 32'd99);
        fwd_a = 0;
        tick();
        chk("tp_fwd_off", 32'(rd1_e), 32'd10);

        // Stall / flush
        valid_d = 1; ctrl_d = 16'hBEEF; pc_d = 9'h040;
        tick();
        chk("tp_load_ctrl", 32'(ctrl_e), 32'hBEEF);
        stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            ctrl_d = 16'(16'h1000 + i); pc_d = 9'(i + 1); ra1_d = 5'd7;
            tick();
        end
        chk("tp_stall_ctrl", 32'(ctrl_e), 32'hBEEF);
        chk("tp_stall_pc", 32'(pc_e), 32'h040);
        chk("tp_stall_cnt3", 32'(stall_cnt), 32'd3);
        flush_d = 1;
        tick();
        chk("tp_flush_valid", 32'(valid_e), 32'd0);
        chk("tp_flush_ctrl", 32'(ctrl_e), 32'd0);
        chk("tp_flush_cnt", 32'(stall_cnt), 32'd3);
        stall_d = 0; flush_d = 0; valid_d = 0; ctrl_d = 16'h1234;
        tick();
        chk("tp_invalid_ctrl", 32'(ctrl_e), 32'd0);

        // Counter saturation
        stall_d = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("tp_cnt_sat", 32'(stall_cnt), 32'hF);
        stall_d = 0;

        // Mid-stream asynchronous reset back to all-bubble
        rand_inputs();
        stall_d = 0; flush_d = 0; valid_d = 1;
        tick();
        #2;
        rst = 0;
        #1;
        model_reset();
        check_all();
        chk("tp_async_valid", 32'(valid_e), 32'd0);
        tick();
        rst = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage for the pipelined core. It holds the architectural register file with write-first bypass, three read ports with external forwarding overrides, and branch-and-link write-back. It ends in an ID/EX pipeline register that supports stall, flush/bubble insertion and a valid bit. It sits between the fetch/decode instruction register and the execute stage. The control unit stays external and feeds its decoded control bundle in as `ctrl_d`.

## Interface
Parameters:
- DATA_W, 18, register/operand width
- PC_W, 9, program-counter width (PC_W ≤ DATA_W)
- ADDR_W, 5, register address width
- NREGS, 32, number of registers (≤ 2^ADDR_W)
- CTRL_W, 16, width of control bundle from control unit
- LINK_REG, 29, register whose low PC_W bits are exported as link/return address
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_d  in  1  hold ID/EX register
- flush_d  in  1  insert bubble into ID/EX register
- valid_d  in  1  instruction in D is valid
- ctrl_d  in  CTRL_W  decoded control bundle
- imm_d  in  DATA_W  immediate field
- ra1_d, ra2_d, ra3_d  in  ADDR_W  read addresses
- rd_d  in  ADDR_W  destination address
- pc_d, pcplus_d  in  PC_W  PC and PC+4 of D instruction
- fwd_a, fwd_b, fwd_c  in  1  override read port 1/2/3 with `result_w`
- we_w  in  1  write-back enable
- link_w  in  1  write-back is branch-link (write `pc_w`)
- wa_w  in  ADDR_W  write-back address
- result_w  in  DATA_W  write-back result
- pc_w  in  PC_W  PC for link write-back
- valid_e  out  1  E instruction valid
- ctrl_e  out  CTRL_W  control bundle
- rd1_e, rd2_e, rd3_e  out  DATA_W  operands
- imm_e  out  DATA_W  immediate
- rs1_e, rs2_e, rs3_e, rd_e  out  ADDR_W  addresses (for hazard unit)
- pc_e, pcplus_e, link_e  out  PC_W  PCs, link register snapshot
- stall_cnt  out  CNT_W  saturating stall-cycle counter

## Operation
- Write data `wd` = `link_w ? {zeros, pc_w} : result_w`.
- Register 0 always reads 0. Writes to register 0 are dropped. Addresses ≥ NREGS read 0, and writes to them are dropped.
- Register write: at the rising edge when `we_w=1`, `regs[wa_w] <= wd`.
- Read port n, combinational, in priority order:
  - `fwd_n=1` → `result_w`
  - `we_w` && `wa_w==ran_d` && `ran_d≠0` → `wd` (write-first bypass)
  - otherwise → `regs[ran_d]`
- `link_d` = `regs[LINK_REG][PC_W-1:0]`, with the same bypass applied.
- ID/EX update at each rising edge, in priority order:
  - `flush_d=1`: `valid_e=0`, `ctrl_e=0`, all other E outputs 0.
  - else `stall_d=1`: all E outputs hold.
  - else load: `valid_e<=valid_d`, `ctrl_e<=valid_d ? ctrl_d : 0`. All data, address and PC fields load from their D counterparts: `rd*_e` from the read-port results, `link_e` from `link_d`, `rs*_e` from `ra*_d`.
- Register-file writes are independent of stall and flush. Write-back always completes.
- `stall_cnt`:
  - increments on each edge with `stall_d=1` and `flush_d=0`
  - saturates at all-ones
  - cleared only by reset

## Timing
- Reset (rst=0, asynchronous): all registers, all E outputs and `stall_cnt` go to 0 immediately. Clocks are ignored while reset is low. Deasserting reset mid-stream restarts from an all-bubble state.
- Read paths are combinational within the D cycle. E outputs have 1-cycle latency.
- A write and a read of the same register in the same cycle: the read returns the new value (bypass). From the next cycle on, the stored value is returned.
- During a stall, held E operands are not refreshed by later writes. Resolving that is the hazard unit's job via E-stage forwarding.
- `flush_d` and `stall_d` asserted together: flush wins, and the counter does not increment.

## Test plan
- Reset then write: with rst low, assert `we_w=1`, `wa_w=5`, `result_w=18'h2A5A5`. Outputs stay 0 and no write occurs. Release reset and repeat the write. A read of `ra1_d=5` on the next cycle gives `rd1_e=18'h2A5A5` one cycle later.
- Bypass and R0: same cycle `we_w`, `wa_w=7`, `result_w=18'h00123`, `ra2_d=7` gives `rd2_e=18'h00123` next edge. A write of `18'h3FFFF` to R0 followed by a read of R0 returns 0.
- Branch-link: `we_w=1`, `link_w=1`, `wa_w=29`, `pc_w=9'h1A4`. Next read of R29 gives `18'h001A4`, and `link_e=9'h1A4` on the next load.
- Forward priority: `regs[3]=10`, `fwd_a=1`, `result_w=99`, `ra1_d=3` gives `rd1_e=99`. With `fwd_a=0` and no write-back, it gives 10.
- Stall/flush:
  - load `ctrl_d=16'hBEEF` (valid) → `ctrl_e=16'hBEEF`
  - then 3 cycles stall with new inputs → E unchanged, `stall_cnt=3`
  - then stall+flush together → `valid_e=0`, `ctrl_e=0`, count still 3
  - `valid_d=0` load → `ctrl_e=0`
- Counter saturation: with CNT_W=4, hold `stall_d=1` for 20 cycles → `stall_cnt=4'hF` with no wrap.
